// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite bus types plus the SRAM responder state encoding.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } HRESP_state;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } HBURST_Type;

    localparam logic [2:0] WORD  = 3'b010;
    localparam logic       READ  = 1'b0;
    localparam logic       WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } slave_state;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/ahb3lite_sram_array.sv
// DEPTH x 32 word store: synchronous write, combinational read, no reset.
module ahb3lite_sram_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          HCLK,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge HCLK) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite SRAM responder with OKAY/ERROR responses.
// Define AHB_SLV_WAIT_EN to honour WAIT_STATES; otherwise every OKAY is zero-wait.
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  HBURST_Type  HBURST,
    input  HTRANS_state HTRANS,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output HRESP_state  HRESP
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0 ||
        WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_param
        $error("ahb3lite_sram_slave: DEPTH or WAIT_STATES out of range");
    end

    slave_state    state, state_n;
    logic          dp_valid, dp_valid_n;
    logic          dp_write, dp_write_n;
    logic [AW-1:0] idx_q, idx_q_n;
    logic [31:0]   idx;
    logic          active, legal, accept, wr_en;
    logic [31:0]   rd_word;
    logic          unused_burst;

`ifdef AHB_SLV_WAIT_EN
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_n;
`endif

    assign unused_burst = ^HBURST;

    assign idx    = HADDR - BASE_ADDR;
    assign active = HSEL && (HTRANS == NONSEQ || HTRANS == SEQ);
    assign legal  = (idx < 32'(DEPTH)) && (HSIZE == WORD);
    assign HREADY = (state == S_IDLE) || (state == S_ERR2);
    assign HRESP  = (state == S_ERR1 || state == S_ERR2) ? ERROR : OKAY;
    assign accept = HREADY && active;

    // dp_valid is only ever set for legal transfers, so a ready data phase is an OKAY one.
    // A reset at the closing edge drops the write.
    assign wr_en  = HREADY && dp_valid && dp_write && !HRESET;

    // The write lands at the edge ending its data phase and the read port is
    // combinational, so a read issued at that same edge already sees new data.
    assign HRDATA = (HREADY && dp_valid && !dp_write) ? rd_word : 32'h0;

    always_comb begin
        state_n    = state;
        dp_valid_n = dp_valid;
        dp_write_n = dp_write;
        idx_q_n    = idx_q;
`ifdef AHB_SLV_WAIT_EN
        wait_cnt_n = wait_cnt;
`endif
        case (state)
            S_IDLE, S_ERR2: begin
                state_n    = S_IDLE;
                dp_valid_n = 1'b0;
                if (accept) begin
                    if (legal) begin
                        dp_valid_n = 1'b1;
                        dp_write_n = HWRITE;
                        idx_q_n    = idx[AW-1:0];
`ifdef AHB_SLV_WAIT_EN
                        if (WAIT_STATES != 0) begin
                            state_n    = S_WAIT;
                            wait_cnt_n = WAIT_CNT_W'(WAIT_STATES);
                        end
`endif
                    end else begin
                        state_n = S_ERR1;
                    end
                end
            end
            S_WAIT: begin
`ifdef AHB_SLV_WAIT_EN
                if (wait_cnt <= 1) state_n = S_IDLE;
                else wait_cnt_n = wait_cnt - 1'b1;
`else
                state_n = S_IDLE;
`endif
            end
            S_ERR1:  state_n = S_ERR2;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= S_IDLE;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            idx_q    <= '0;
`ifdef AHB_SLV_WAIT_EN
            wait_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            dp_valid <= dp_valid_n;
            dp_write <= dp_write_n;
            idx_q    <= idx_q_n;
`ifdef AHB_SLV_WAIT_EN
            wait_cnt <= wait_cnt_n;
`endif
        end
    end

    ahb3lite_sram_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_array (
        .HCLK (HCLK),
        .we   (wr_en),
        .addr (idx_q),
        .wdata(HWDATA),
        .rdata(rd_word)
    );

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Scoreboard bench for ahb3lite_sram_slave: driver queues expected completions, monitor checks them.
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    localparam logic [31:0] B = 32'h0000_0100;
    localparam int          D = 64;
`ifdef AHB_SLV_WAIT_EN
    localparam int WEFF = 3;
`else
    localparam int WEFF = 0;
`endif

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    HBURST_Type  HBURST;
    HTRANS_state HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    HRESP_state  HRESP;

    ahb3lite_sram_slave #(
        .BASE_ADDR  (B),
        .DEPTH      (D),
        .WAIT_STATES(3)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .HSEL  (HSEL),
        .HADDR (HADDR),
        .HWRITE(HWRITE),
        .HSIZE (HSIZE),
        .HBURST(HBURST),
        .HTRANS(HTRANS),
        .HWDATA(HWDATA),
        .HRDATA(HRDATA),
        .HREADY(HREADY),
        .HRESP (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          low;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        mon_dp = 1'b0;
    int          mon_low = 0;
    logic [31:0] pend_wd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: tracks data phases from the bus inputs and checks each completion.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (mon_en) begin
                if (HRESET) begin
                    mon_dp = 1'b0;
                end else begin
                    if (mon_dp) begin
                        if (HREADY) begin
                            if (sbq.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_completion actual=none_queued at %0t", $time);
                            end else begin
                                e = sbq.pop_front();
                                chk("hresp", 32'(HRESP), 32'(e.err));
                                chk("wait_cycles", 32'(mon_low), 32'(e.low));
                                chk("hrdata", HRDATA, e.data);
                            end
                            mon_dp = 1'b0;
                        end else begin
                            mon_low++;
                            if (sbq.size() != 0) chk("hresp_stall", 32'(HRESP), 32'(sbq[0].err));
                        end
                    end else begin
                        chk("idle_hready", 32'(HREADY), 32'd1);
                        chk("idle_hrdata", HRDATA, 32'h0);
                    end
                    if (HREADY && HSEL && (HTRANS == NONSEQ || HTRANS == SEQ)) begin
                        mon_dp  = 1'b1;
                        mon_low = 0;
                    end
                end
            end
        end
    end

    // Called just after a posedge; returns just after the edge that accepts the address phase.
    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge HCLK);
        while (!HREADY && n < 40) begin
            n++;
            @(negedge HCLK);
        end
        chk({name, "_hready_timeout"}, 32'(HREADY), 32'd1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic xfer(input HTRANS_state tr, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input logic err,
                        input logic [31:0] rexp, input bit push);
        exp_t e;
        HSEL   = 1'b1;
        HTRANS = tr;
        HWRITE = wr;
        HADDR  = a;
        HSIZE  = sz;
        HBURST = INCR;
        HWDATA = pend_wd;
        wait_ready("xfer");
        pend_wd = wd;
        if (push) begin
            e.err  = err;
            e.data = (wr || err) ? 32'h0 : rexp;
            e.low  = err ? 1 : WEFF;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        HSEL   = 1'b0;
        HTRANS = IDLE;
        HWRITE = READ;
        HWDATA = pend_wd;
        wait_ready("idle");
        pend_wd = 32'h0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HADDR  = 32'h0;
        HWRITE = READ;
        HSIZE  = WORD;
        HBURST = SINGLE;
        HTRANS = IDLE;
        HWDATA = 32'h0;

        repeat (2) begin
            @(negedge HCLK);
            chk("rst_hready", 32'(HREADY), 32'd1);
            chk("rst_hresp", 32'(HRESP), 32'(OKAY));
            chk("rst_hrdata", HRDATA, 32'h0);
        end
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        mon_en = 1'b1;

        // zero-wait write then read
        xfer(NONSEQ, WRITE, B + 32'h5, WORD, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        xfer(NONSEQ, READ,  B + 32'h5, WORD, 32'h0,       1'b0, 32'hDEADBEEF, 1'b1);
        xfer(NONSEQ, WRITE, B + 32'h0, WORD, 32'h0000_0A0A, 1'b0, 32'h0, 1'b1);
        xfer(NONSEQ, WRITE, B + 32'd63, WORD, 32'hCAFE_0063, 1'b0, 32'h0, 1'b1);
        xfer(NONSEQ, READ,  B + 32'd63, WORD, 32'h0, 1'b0, 32'hCAFE_0063, 1'b1);
        idle();

        // INCR burst write, then read-after-write on the last beat
        xfer(NONSEQ, WRITE, B + 32'h10, WORD, 32'd1, 1'b0, 32'h0, 1'b1);
        xfer(SEQ,    WRITE, B + 32'h11, WORD, 32'd2, 1'b0, 32'h0, 1'b1);
        xfer(SEQ,    WRITE, B + 32'h12, WORD, 32'd3, 1'b0, 32'h0, 1'b1);
        xfer(SEQ,    WRITE, B + 32'h13, WORD, 32'd4, 1'b0, 32'h0, 1'b1);
        xfer(NONSEQ, READ,  B + 32'h13, WORD, 32'h0, 1'b0, 32'd4, 1'b1);
        xfer(NONSEQ, READ,  B + 32'h10, WORD, 32'h0, 1'b0, 32'd1, 1'b1);
        xfer(SEQ,    READ,  B + 32'h11, WORD, 32'h0, 1'b0, 32'd2, 1'b1);
        xfer(SEQ,    READ,  B + 32'h12, WORD, 32'h0, 1'b0, 32'd3, 1'b1);
        idle();

        // errors: past the top, below base, bad size; each next transfer lands in S_ERR2
        xfer(NONSEQ, WRITE, B + 32'd64, WORD, 32'h6464_6464, 1'b1, 32'h0, 1'b1);
        xfer(NONSEQ, WRITE, B - 32'd1,  WORD, 32'h1111_1111, 1'b1, 32'h0, 1'b1);
        xfer(NONSEQ, WRITE, B + 32'h5,  3'b001, 32'h0000_0BAD, 1'b1, 32'h0, 1'b1);
        xfer(NONSEQ, READ,  B + 32'h5,  WORD, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        xfer(NONSEQ, READ,  B + 32'h0,  WORD, 32'h0, 1'b0, 32'h0000_0A0A, 1'b1);
        xfer(NONSEQ, READ,  B + 32'd63, WORD, 32'h0, 1'b0, 32'hCAFE_0063, 1'b1);
        xfer(NONSEQ, READ,  B + 32'h5,  3'b000, 32'h0, 1'b1, 32'h0, 1'b1);
        idle();

        // reset while a write to 0x7 is still in its data phase
        xfer(NONSEQ, WRITE, B + 32'h7, WORD, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b1);
        idle();
        xfer(NONSEQ, WRITE, B + 32'h7, WORD, 32'hFFFF_0000, 1'b0, 32'h0, 1'b0);
        HSEL   = 1'b0;
        HTRANS = IDLE;
        HWDATA = 32'hFFFF_0000;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET  = 1'b0;
        pend_wd = 32'h0;
        @(negedge HCLK);
        chk("post_rst_hready", 32'(HREADY), 32'd1);
        chk("post_rst_hresp", 32'(HRESP), 32'(OKAY));
        @(posedge HCLK);
        #1;
        xfer(NONSEQ, READ, B + 32'h7, WORD, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b1);
        idle();

        repeat (3) @(posedge HCLK);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
- AHB-Lite responder (slave) with a word-organised local SRAM.
- Answers NONSEQ/SEQ transfers from the CPU/DMA master: writes store HWDATA, reads return HRDATA.
- Inserts programmable wait states and gives the two-cycle ERROR response for illegal transfers.
- Sits at the far end of the single-master AHB-Lite bus, so its HREADY output is the bus HREADY.

Parameters:
- BASE_ADDR, 32'h0000_0000, first word address decoded by this slave.
- DEPTH, 64, number of 32-bit words; must be a power of 2, range 2..1024.
- WAIT_STATES, 0, extra HREADY-low cycles per OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  bus clock; all logic on posedge.
- HRESET  in  1  synchronous reset, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  word address; consecutive words differ by 1.
- HWRITE  in  1  WRITE=1, READ=0.
- HSIZE  in  3  transfer size; only WORD is legal.
- HBURST  in  HBURST_Type  burst type; accepted, not used for addressing.
- HTRANS  in  HTRANS_state  IDLE/BUSY/NONSEQ/SEQ.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data, valid when HREADY=1 in a read data phase.
- HREADY  out  1  transfer-complete / address-accept.
- HRESP  out  HRESP_state  OKAY/ERROR.

Behaviour:
- Reset (HRESET=1 at posedge): HREADY=1, HRESP=OKAY, HRDATA=0, state S_IDLE, pending data phase discarded (a write in flight is NOT committed). SRAM contents are not cleared.
- Address phase sampled only at a posedge with HREADY=1. The transfer is "active" when HSEL=1 and HTRANS is NONSEQ or SEQ.
- Index = HADDR - BASE_ADDR, 32-bit unsigned.
- Transfer is legal when index < DEPTH and HSIZE==WORD; otherwise it is illegal.
- IDLE, BUSY or HSEL=0 in the address phase: next cycle is a zero-wait OKAY, HREADY=1, no memory access.
- States (slave_state): S_IDLE, S_WAIT, S_ERR1, S_ERR2.
- S_IDLE, transfer accepted:
  - legal and WAIT_STATES=0: stay S_IDLE; next cycle HREADY=1, HRESP=OKAY.
  - legal and WAIT_STATES>0: go S_WAIT, wait counter = WAIT_STATES.
  - illegal: go S_ERR1.
- S_WAIT: HREADY=0, HRESP=OKAY. Counter decrements each cycle. When it reaches 1, the next cycle is the completing cycle (HREADY=1, state S_IDLE). Address/control inputs are ignored while HREADY=0.
- S_ERR1: HREADY=0, HRESP=ERROR. Always goes to S_ERR2 on the next clock.
- S_ERR2: HREADY=1, HRESP=ERROR. Address phase is sampled as in S_IDLE; the master may cancel with IDLE.
- Write commit: mem[index] <= HWDATA at the posedge that ends the write data phase with HREADY=1 and OKAY. Errored writes never modify memory.
- Read: HRDATA = mem[index_q] during the completing cycle; 0 in every other cycle.
- Read-after-write forwarding: a write completing at the same edge that ends a read address phase to the same index must return the new HWDATA on that read.
- Latency: read or write completes 1+WAIT_STATES cycles after address-phase acceptance. ERROR always takes 2 cycles.
- Back-to-back pipelined transfers are sustained at one per cycle when WAIT_STATES=0.
- Index arithmetic wraps modulo 2^32. An HADDR below BASE_ADDR produces a huge index and is therefore an error.

Optional Feature:
- Macro: AHB_SLV_WAIT_EN.
- Defined: WAIT_STATES is honoured and S_WAIT exists.
- Undefined: WAIT_STATES is ignored, every OKAY transfer is zero-wait, and no wait-counter logic is synthesised. The ERROR path is unchanged.

Decomposition:
- Add to ahb3lite_pkg:
  - enum slave_state {S_IDLE, S_WAIT, S_ERR1, S_ERR2}.
  - localparam WAIT_CNT_W=4.
  - Reuse the existing HTRANS_state, HRESP_state, HBURST_Type, WORD, READ/WRITE.
- One sub-module, ahb3lite_sram_array: DEPTH x 32, synchronous write port, combinational read port.
- Forwarding and control stay in the top.

Test Plan:
- Reset then idle: HRESET=1 for 2 cycles, HTRANS=IDLE -> HREADY=1, HRESP=OKAY, HRDATA=0 throughout.
- Zero-wait write/read: NONSEQ WRITE HADDR=0x5, HWDATA=0xDEADBEEF, then NONSEQ READ 0x5 -> read completes one cycle after its address phase with HRDATA=0xDEADBEEF and OKAY.
- Pipelined INCR burst with forwarding: write 0x10..0x13 with data 1..4, then immediately read 0x13 -> returns 4 with no stall; reads of 0x10..0x12 return 1..3.
- Wait states (AHB_SLV_WAIT_EN defined, WAIT_STATES=3): single read -> HREADY low exactly 3 cycles, then high with data.
- Error: write HADDR=BASE_ADDR+64 (DEPTH=64), or HSIZE!=WORD -> HREADY=0/ERROR, then HREADY=1/ERROR; memory unchanged on readback; next NONSEQ accepted in S_ERR2.
- Reset mid-wait: assert HRESET during S_WAIT of a write to 0x7 -> next cycle HREADY=1/OKAY, and mem[0x7] keeps its old value.
